// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared state encoding, BCD constants and the
// MM:SS BCD increment used by the game_timer elapsed-time counter.
package game_timer_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_ones;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } bcd_time_t;

    localparam bcd_time_t TIME_MAX = '{
        min_tens: DIGIT_MAX,
        min_ones: DIGIT_MAX,
        sec_tens: SEC_TENS_MAX,
        sec_ones: DIGIT_MAX
    };

    // min_tens never wraps: the caller stops counting at 99:59.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec_ones != DIGIT_MAX) begin
            r.sec_ones = t.sec_ones + 4'd1;
        end else begin
            r.sec_ones = '0;
            if (t.sec_tens != SEC_TENS_MAX) begin
                r.sec_tens = t.sec_tens + 4'd1;
            end else begin
                r.sec_tens = '0;
                if (t.min_ones != DIGIT_MAX) begin
                    r.min_ones = t.min_ones + 4'd1;
                end else begin
                    r.min_ones = '0;
                    r.min_tens = t.min_tens + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_timer_tick_edge_sync.sv
// tick_edge_sync: multi-flop synchroniser plus history flop, emitting
// a one-cycle pulse on each rising edge of an asynchronous level.
module tick_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic level_in,
    output logic pulse_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], level_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign pulse_out = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/game_timer.sv
// game_timer: MM:SS BCD elapsed-time counter with start/pause/clear.
// Define GAME_TIMER_LIMIT_EN to stop at LIMIT_MIN:LIMIT_SEC as well as 99:59.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LIMIT_MIN   = 10,
    parameter int LIMIT_SEC   = 0
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             tick_in,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic             running,
    output logic             time_up
);

    localparam bit LIMIT_EN =
`ifdef GAME_TIMER_LIMIT_EN
        1'b1;
`else
        1'b0;
`endif

    localparam bcd_time_t LIMIT = '{
        min_tens: BCD_W'(LIMIT_MIN / 10),
        min_ones: BCD_W'(LIMIT_MIN % 10),
        sec_tens: BCD_W'(LIMIT_SEC / 10),
        sec_ones: BCD_W'(LIMIT_SEC % 10)
    };

    localparam bit LIMIT_ZERO = LIMIT_EN && (LIMIT == '0);

    state_t    r_state;
    bcd_time_t r_time;
    logic      r_running;
    logic      r_time_up;

    state_t    w_state_nxt;
    bcd_time_t w_time_nxt;
    bcd_time_t w_inc;
    logic      w_tick;
    logic      w_stop;

    tick_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_sync (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .level_in  (tick_in),
        .pulse_out (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time;
        w_inc       = bcd_inc(r_time);
        w_stop      = (w_inc == TIME_MAX) ||
                      (LIMIT_EN && (w_inc == LIMIT));
        if (clear) begin
            w_state_nxt = IDLE;
            w_time_nxt  = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = LIMIT_ZERO ? DONE : RUN;
                    end
                end
                RUN: begin
                    // start overrides a simultaneous pause, so the tick survives
                    if (pause && !start) begin
                        w_state_nxt = PAUSE;
                    end else if (w_tick) begin
                        w_time_nxt = w_inc;
                        if (w_stop) begin
                            w_state_nxt = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        w_state_nxt = RUN;
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_time    <= '0;
            r_running <= 1'b0;
            r_time_up <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_time    <= w_time_nxt;
            r_running <= (w_state_nxt == RUN);
            r_time_up <= (w_state_nxt == DONE);
        end
    end

    assign sec_ones = r_time.sec_ones;
    assign sec_tens = r_time.sec_tens;
    assign min_ones = r_time.min_ones;
    assign min_tens = r_time.min_tens;
    assign running  = r_running;
    assign time_up  = r_time_up;

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: random stimulus against a seconds-count reference model;
// a negedge monitor checks every output change against a scoreboard queue.
module tb_game_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] so, st, mo, mt;
    logic       running, time_up;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    game_timer #(
        .SYNC_STAGES (2),
        .LIMIT_MIN   (0),
        .LIMIT_SEC   (10)
    ) dut (
        .clock_in (clk),
        .reset_n  (rst_n),
        .tick_in  (tick_in),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .sec_ones (so),
        .sec_tens (st),
        .min_ones (mo),
        .min_tens (mt),
        .running  (running),
        .time_up  (time_up)
    );

`ifdef GAME_TIMER_LIMIT_EN
    localparam int LIMS = 10;
`else
    localparam int LIMS = -1;
`endif
    localparam int MAXS = 99 * 60 + 59;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
    typedef struct {
        int          edge_n;
        logic [17:0] obs;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_secs = 0;
    mst_t m_st = M_IDLE;

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [17:0] model_obs();
        return {to_bcd(m_secs), m_st == M_RUN, m_st == M_DONE};
    endfunction

    function automatic void push_if_changed(input int e, input logic [17:0] old);
        exp_t x;
        if (model_obs() != old) begin
            x.edge_n = e;
            x.obs    = model_obs();
            q.push_back(x);
        end
    endfunction

    // Effect of one clock edge on the model, given what the DUT sees there.
    function automatic void model_edge(input int e, input bit tk,
                                       input bit s, input bit p, input bit c);
        logic [17:0] old;
        old = model_obs();
        if (c) begin
            m_st   = M_IDLE;
            m_secs = 0;
        end else begin
            case (m_st)
                M_IDLE:  if (s) m_st = (LIMS == 0) ? M_DONE : M_RUN;
                M_RUN: begin
                    if (p && !s) begin
                        m_st = M_PAUSE;
                    end else if (tk) begin
                        m_secs++;
                        if (m_secs == MAXS || m_secs == LIMS) m_st = M_DONE;
                    end
                end
                M_PAUSE: if (s) m_st = M_RUN;
                default: ;
            endcase
        end
        push_if_changed(e, old);
    endfunction

    function automatic logic [17:0] obs_now();
        return {mt, mo, st, so, running, time_up};
    endfunction

    task automatic chk(input string nm, input logic [17:0] got,
                       input logic [17:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    logic [17:0] last_obs = '0;
    always @(negedge clk) begin
        logic [17:0] obs;
        exp_t        e;
        obs = obs_now();
        if (obs !== last_obs) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change cyc=%0d got=%h", cyc, obs);
            end else begin
                e = q.pop_front();
                if (obs !== e.obs || cyc != e.edge_n) begin
                    n_fail++;
                    $display("FAIL event got=%h@%0d exp=%h@%0d",
                             obs, cyc, e.obs, e.edge_n);
                end
            end
            last_obs = obs;
        end
    end

    task automatic wait_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input bit s, input bit p, input bit c);
        start = s;
        pause = p;
        clear = c;
        model_edge(cyc + 1, 1'b0, s, p, c);
        wait_edge();
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
    endtask

    task automatic tick(input int h, input int g);
        int n;
        n = cyc;
        tick_in = 1'b1;
        model_edge(n + 3, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (h) wait_edge();
        tick_in = 1'b0;
        repeat (g) wait_edge();
        while (cyc < n + 3) wait_edge();
    endtask

    task automatic tick_rand();
        tick(int'($urandom_range(1, 4)), int'($urandom_range(1, 6)));
    endtask

    task automatic fast_tick();
        tick_in = 1'b1;
        model_edge(cyc + 3, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_edge();
        tick_in = 1'b0;
        wait_edge();
    endtask

    // Tick edge and pause land on the same clock edge.
    task automatic tick_with_pause();
        int n;
        n = cyc;
        tick_in = 1'b1;
        model_edge(n + 3, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_edge();
        wait_edge();
        pause = 1'b1;
        wait_edge();
        pause = 1'b0;
        tick_in = 1'b0;
        wait_edge();
    endtask

    initial begin
        logic [17:0] exp_sat;
        repeat (3) wait_edge();
        chk("reset", obs_now(), 18'h0);
        rst_n = 1'b1;
        wait_edge();

        pulse(1'b1, 1'b0, 1'b0);
        repeat (3) tick(10, 10);
        chk("run_0003", obs_now(), {16'h0003, 1'b1, 1'b0});

        repeat (2) tick_rand();
        chk("run_0005", obs_now(), {16'h0005, 1'b1, 1'b0});
        pulse(1'b0, 1'b1, 1'b0);
        repeat (4) tick_rand();
        chk("paused_0005", obs_now(), {16'h0005, 1'b0, 1'b0});
        pulse(1'b1, 1'b0, 1'b0);
        tick_rand();
        chk("resume_0006", obs_now(), {16'h0006, 1'b1, 1'b0});
        tick_with_pause();
        chk("tick_pause_drop", obs_now(), {16'h0006, 1'b0, 1'b0});
        pulse(1'b1, 1'b1, 1'b0);
        chk("sp_in_pause", obs_now(), {16'h0006, 1'b1, 1'b0});
        pulse(1'b1, 1'b1, 1'b0);
        chk("sp_in_run", obs_now(), {16'h0006, 1'b1, 1'b0});

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: tick_rand();
                6: pulse(1'b1, 1'b0, 1'b0);
                7: pulse(1'b0, 1'b1, 1'b0);
                8: pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                default: pulse(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            endcase
            repeat ($urandom_range(0, 3)) wait_edge();
        end
        chk("random_phase", obs_now(), model_obs());

        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (42) fast_tick();
        repeat (4) wait_edge();
        chk("pre_reset", obs_now(), model_obs());
        #1;
        rst_n = 1'b0;
        begin
            logic [17:0] old;
            old = model_obs();
            m_st = M_IDLE;
            m_secs = 0;
            push_if_changed(cyc, old);
        end
        #1;
        chk("async_reset", obs_now(), 18'h0);
        wait_edge();
        rst_n = 1'b1;
        wait_edge();

        pulse(1'b1, 1'b0, 1'b0);
        repeat (2) tick_rand();
        pulse(1'b1, 1'b0, 1'b1);
        chk("clear_start", obs_now(), 18'h0);

        pulse(1'b1, 1'b0, 1'b0);
        repeat (6010) fast_tick();
        repeat (5) wait_edge();
`ifdef GAME_TIMER_LIMIT_EN
        exp_sat = {16'h0010, 1'b0, 1'b1};
`else
        exp_sat = {16'h9959, 1'b0, 1'b1};
`endif
        chk("saturate", obs_now(), exp_sat);
        pulse(1'b0, 1'b0, 1'b1);
        chk("clear_done", obs_now(), 18'h0);

        repeat (5) wait_edge();
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain left=%0d required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Elapsed-time counter for the Sudoku game, directly downstream of the clock divider.
- Consumes the divider's slow square wave (1 Hz at default divider settings) as a level input.
- Synchronises and edge-detects that wave in the system clock domain, then counts MM:SS in BCD for the 7-segment display stage.
- Provides start/pause/clear control, and saturates or stops at a time limit.

Parameters:
- SYNC_STAGES, 2, number of flops in the tick_in synchroniser; legal range 2..3.
- LIMIT_MIN, 10, minutes value of the limit; used only when GAME_TIMER_LIMIT_EN is defined; legal range 0..99.
- LIMIT_SEC, 0, seconds value of the limit; used only when GAME_TIMER_LIMIT_EN is defined; legal range 0..59.

Ports:
- clock_in, input, 1, system clock; all state is updated on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- tick_in, input, 1, divided clock from the divider; each rising edge counts one second.
- start, input, 1, one-cycle pulse; begins or resumes counting.
- pause, input, 1, one-cycle pulse; freezes counting.
- clear, input, 1, one-cycle pulse; returns to 00:00 idle.
- sec_ones, output, 4, BCD 0..9.
- sec_tens, output, 4, BCD 0..5.
- min_ones, output, 4, BCD 0..9.
- min_tens, output, 4, BCD 0..9.
- running, output, 1, high while in RUN.
- time_up, output, 1, high while in DONE.

Behaviour:
- Reset: one clock (clock_in); reset is asynchronous and active-low (reset_n).
- While reset_n is low, all of the following hold:
  - all digits are 0;
  - running=0 and time_up=0;
  - state=IDLE;
  - synchroniser flops and edge-history flop are 0.
- Tick path:
  - tick_in passes through SYNC_STAGES flops, then one history flop.
  - tick_edge = last sync stage AND NOT history.
  - With SYNC_STAGES=2, digits change on the 3rd rising clock_in edge after tick_in rises.
  - A falling edge of tick_in never counts.
  - A tick_in high time shorter than one clock period may be missed; this is not an error.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE: start -> RUN.
  - RUN: pause -> PAUSE; limit reached -> DONE.
  - PAUSE: start -> RUN.
  - DONE: stays in DONE until clear.
  - clear from any state -> IDLE with digits = 00:00.
- Simultaneous control pulses: priority is clear > start > pause.
  - start+pause in RUN: stay in RUN.
  - start+pause in PAUSE: go to RUN.
- Counting happens only in RUN on tick_edge.
  - A tick_edge in the same cycle as pause or clear is dropped.
  - A tick_edge in the same cycle as start from IDLE or PAUSE is not counted.
- BCD increment and carries:
  - sec_ones 9->0 with carry;
  - sec_tens 5->0 with carry;
  - min_ones 9->0 with carry;
  - min_tens increments 0..9.
- Saturation: without the optional feature, reaching 99:59 moves to DONE on that same edge, and digits hold at 99:59.
- Outputs: running and time_up are registered and follow the state; they are never both high.
- Mid-operation: a reset_n assertion at any time forces the reset values immediately, with no extra clock required.

Optional Feature:
- Macro: GAME_TIMER_LIMIT_EN.
- Defined:
  - After the increment producing LIMIT_MIN:LIMIT_SEC, state goes to DONE on that same edge and time_up rises.
  - The 99:59 saturation still applies if the limit is never reached.
  - A limit of 00:00 means DONE is entered on the first start.
- Undefined:
  - Limit parameters are ignored.
  - Only 99:59 saturation produces DONE.

Decomposition:
- Shared package game_timer_pkg:
  - state typedef {IDLE, RUN, PAUSE, DONE};
  - BCD_W=4;
  - constants SEC_TENS_MAX=5 and DIGIT_MAX=9.
- One sub-module: tick_edge_sync.
  - Parameter SYNC_STAGES.
  - Ports: clock_in, reset_n, level_in, pulse_out.
  - Reusable for the button inputs elsewhere in the design.

Test Plan:
- Reset, then start, then 3 tick_in rising edges spaced 20 clocks apart -> 00:03, running=1; each digit change occurs exactly 3 clocks after its tick_in rise.
- Preload to 00:59 via ticks, then one tick -> 01:00; preload to 09:59, then one tick -> 10:00.
- RUN at 00:05; pause; 4 ticks -> still 00:05 and running=0; start; 1 tick -> 00:06.
- Reach 99:59 (macro undefined), then more ticks -> digits hold at 99:59, time_up=1; clear -> 00:00 in IDLE, time_up=0.
- Macro defined with LIMIT 00:10: start, then 12 ticks -> DONE at 00:10 on the 10th tick, later ticks ignored.
- Assert reset_n low mid-RUN at 00:42, asynchronously between clock edges -> outputs go to 00:00 and running=0 before the next clock edge; clear and start in the same cycle -> IDLE.
